// File: rtl/butterfly2_stream_pkg.sv
// butterfly2_stream_pkg: pipeline latency, intermediate width (N+2), round-half-up and saturate helpers
package butterfly2_stream_pkg;
  localparam int LATENCY = 3;
  function automatic int iw(input int n);
    return n + 2;
  endfunction
  function automatic logic signed [63:0] rnd(input logic signed [63:0] x, input int q);
    return (x + (64'sd1 <<< (q - 1))) >>> q;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/butterfly2_stream_cmul.sv
// cmul_round: 2-stage t = b*W (conj(W) if i_conj) rounded to Q fraction bits; in i_clk,i_en,i_conj,i_b_*,i_w_*; out o_t_* (N+2 bits)
module cmul_round
  import butterfly2_stream_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_conj,
  input  logic [N-1:0]     i_b_re,
  input  logic [N-1:0]     i_b_im,
  input  logic [N-1:0]     i_w_re,
  input  logic [N-1:0]     i_w_im,
  output logic [iw(N)-1:0] o_t_re,
  output logic [iw(N)-1:0] o_t_im
);
  localparam int M = 2 * N;
  localparam int P = 2 * N + 1;
  localparam int W = iw(N);
  logic signed [M-1:0] rr_q, ii_q, ri_q, ir_q;
  logic conj_q;
  logic signed [P-1:0] re_d, im_d;
  always_comb begin
    re_d = conj_q ? P'(rr_q) + P'(ii_q) : P'(rr_q) - P'(ii_q);
    im_d = conj_q ? P'(ir_q) - P'(ri_q) : P'(ri_q) + P'(ir_q);
  end
  always_ff @(posedge i_clk)
    if (i_en) begin
      rr_q <= M'($signed(i_b_re)) * M'($signed(i_w_re));
      ii_q <= M'($signed(i_b_im)) * M'($signed(i_w_im));
      ri_q <= M'($signed(i_b_re)) * M'($signed(i_w_im));
      ir_q <= M'($signed(i_b_im)) * M'($signed(i_w_re));
      conj_q <= i_conj;
      o_t_re <= W'(rnd(64'(re_d), Q));
      o_t_im <= W'(rnd(64'(im_d), Q));
    end
endmodule

// File: rtl/butterfly2_stream.sv
// butterfly2_stream: 3-stage radix-2 butterfly a+/-b*W with valid/ready, optional conj/scale, saturation and sticky o_ovf
module butterfly2_stream
  import butterfly2_stream_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_in0_re,
  input  logic [N-1:0] i_in0_im,
  input  logic [N-1:0] i_in1_re,
  input  logic [N-1:0] i_in1_im,
  input  logic [N-1:0] i_twiddle_re,
  input  logic [N-1:0] i_twiddle_im,
  input  logic         i_conj,
  input  logic         i_scale,
  output logic         o_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out0_re,
  output logic [N-1:0] o_out0_im,
  output logic [N-1:0] o_out1_re,
  output logic [N-1:0] o_out1_im,
  output logic         o_ovf,
  input  logic         i_ovf_clr
);
  localparam int W = iw(N);
  logic en;
  logic v1_q, v2_q, s1_q, s2_q, clip_q;
  logic [N-1:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
  logic [W-1:0] t_re, t_im;
  logic signed [W-1:0] sum_d [4];
  logic signed [63:0] sc_d [4];
  logic signed [63:0] r_d [4];
  logic [3:0] clip_d;
  assign en = !o_valid || i_out_ready;
  assign o_ready = en;
  cmul_round #(.N(N), .Q(Q)) u_cmul (
    .i_clk (i_clk),
    .i_en  (en),
    .i_conj(i_conj),
    .i_b_re(i_in1_re),
    .i_b_im(i_in1_im),
    .i_w_re(i_twiddle_re),
    .i_w_im(i_twiddle_im),
    .o_t_re(t_re),
    .o_t_im(t_im)
  );
  always_comb begin
    sum_d[0] = W'($signed(a2_re_q)) + $signed(t_re);
    sum_d[1] = W'($signed(a2_im_q)) + $signed(t_im);
    sum_d[2] = W'($signed(a2_re_q)) - $signed(t_re);
    sum_d[3] = W'($signed(a2_im_q)) - $signed(t_im);
    for (int k = 0; k < 4; k++) begin
      sc_d[k] = s2_q ? rnd(64'(sum_d[k]), 1) : 64'(sum_d[k]);
      r_d[k] = sat(sc_d[k], N);
      clip_d[k] = r_d[k] != sc_d[k];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) {v1_q, v2_q, o_valid} <= '0;
    else if (en) {v1_q, v2_q, o_valid} <= {i_valid, v1_q, v2_q};
    if (en) begin
      a1_re_q <= i_in0_re;
      a1_im_q <= i_in0_im;
      s1_q <= i_scale;
      a2_re_q <= a1_re_q;
      a2_im_q <= a1_im_q;
      s2_q <= s1_q;
      o_out0_re <= N'(r_d[0]);
      o_out0_im <= N'(r_d[1]);
      o_out1_re <= N'(r_d[2]);
      o_out1_im <= N'(r_d[3]);
      clip_q <= |clip_d;
    end
    o_ovf <= !i_rst && ((o_valid && i_out_ready && clip_q) || (o_ovf && !i_ovf_clr));
  end
endmodule

// File: tb/tb_butterfly2_stream.sv
// tb_butterfly2_stream: randomized and directed self-checking bench for butterfly2_stream (N=16, Q=8)
module tb_butterfly2_stream;
  import butterfly2_stream_pkg::*;
  logic clk = 0, rst = 1, valid = 0, out_ready = 1, conj = 0, scale = 0, ovf_clr = 0;
  logic signed [15:0] a_re = 0, a_im = 0, b_re = 0, b_im = 0, w_re = 0, w_im = 0;
  logic ready, o_valid, ovf;
  logic signed [15:0] o0r, o0i, o1r, o1i;
  int errors = 0, checks = 0;
  typedef struct {longint o0r, o0i, o1r, o1i; bit clip;} beat_t;
  beat_t q[$];
  always #5 clk = ~clk;
  butterfly2_stream #(.N(16), .Q(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_in0_re(a_re), .i_in0_im(a_im), .i_in1_re(b_re), .i_in1_im(b_im),
    .i_twiddle_re(w_re), .i_twiddle_im(w_im), .i_conj(conj), .i_scale(scale),
    .o_valid(o_valid), .i_out_ready(out_ready),
    .o_out0_re(o0r), .o_out0_im(o0i), .o_out1_re(o1r), .o_out1_im(o1i),
    .o_ovf(ovf), .i_ovf_clr(ovf_clr)
  );
  function automatic longint clamp(input longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction
  function automatic beat_t model();
    longint wi, tr, ti;
    longint s[4];
    beat_t e;
    wi = conj ? -longint'(w_im) : longint'(w_im);
    tr = (longint'(b_re) * w_re - longint'(b_im) * wi + 128) >>> 8;
    ti = (longint'(b_re) * wi + longint'(b_im) * w_re + 128) >>> 8;
    s[0] = a_re + tr;
    s[1] = a_im + ti;
    s[2] = a_re - tr;
    s[3] = a_im - ti;
    e.clip = 0;
    for (int k = 0; k < 4; k++) begin
      if (scale) s[k] = (s[k] + 1) >>> 1;
      if (clamp(s[k]) != s[k]) e.clip = 1;
    end
    e.o0r = clamp(s[0]);
    e.o0i = clamp(s[1]);
    e.o1r = clamp(s[2]);
    e.o1i = clamp(s[3]);
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_in();
    a_re = 16'($urandom);
    a_im = 16'($urandom);
    b_re = 16'($urandom);
    b_im = 16'($urandom);
    w_re = 16'(int'($urandom_range(512)) - 256);
    w_im = 16'(int'($urandom_range(512)) - 256);
    conj = 1'($urandom);
    scale = 1'($urandom);
  endtask
  task automatic send(input int ar, ai, br, bi, wr, wi, input bit cj, sc, output int lat);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi); conj = cj; scale = sc;
    valid = 1; out_ready = 1;
    step();
    valid = 0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      step();
      lat++;
    end
  endtask
  task automatic test_reset();
    rst = 1; valid = 1;
    repeat (2) step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b exp 0", o_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b exp 0", ovf); end
    rst = 0; valid = 0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b exp 1", ready); end
    repeat (5) step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset leak: got %b exp 0", o_valid); end
  endtask
  task automatic test_basic();
    int lat;
    send(256, 0, 256, 0, 256, 0, 0, 0, lat);
    checks++; if (lat != LATENCY || o_valid !== 1'b1) begin errors++; $display("FAIL basic latency: got %0d exp %0d", lat, LATENCY); end
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd512, 16'sd0, 16'sd0, 16'sd0}) begin errors++; $display("FAIL basic data: got %0d %0d %0d %0d exp 512 0 0 0", o0r, o0i, o1r, o1i); end
    step();
  endtask
  task automatic test_conj();
    int lat;
    send(0, 0, 256, 0, 0, 256, 1, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd0, -16'sd256, 16'sd0, 16'sd256}) begin errors++; $display("FAIL conj1: got %0d %0d %0d %0d exp 0 -256 0 256", o0r, o0i, o1r, o1i); end
    step();
    send(0, 0, 256, 0, 0, 256, 0, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd0, 16'sd256, 16'sd0, -16'sd256}) begin errors++; $display("FAIL conj0: got %0d %0d %0d %0d exp 0 256 0 -256", o0r, o0i, o1r, o1i); end
    step();
  endtask
  task automatic test_round();
    int lat;
    send(0, 0, 1, 0, 128, 0, 0, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd1, 16'sd0, -16'sd1, 16'sd0}) begin errors++; $display("FAIL round half: got %0d %0d %0d %0d exp 1 0 -1 0", o0r, o0i, o1r, o1i); end
    step();
    send(0, 0, -1, 0, 128, 0, 0, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd0, 16'sd0, 16'sd0, 16'sd0}) begin errors++; $display("FAIL round neg half: got %0d %0d %0d %0d exp 0 0 0 0", o0r, o0i, o1r, o1i); end
    step();
    send(3, 0, 0, 0, 0, 0, 0, 1, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd2, 16'sd0, 16'sd2, 16'sd0}) begin errors++; $display("FAIL scale pos: got %0d %0d %0d %0d exp 2 0 2 0", o0r, o0i, o1r, o1i); end
    step();
    send(-3, 0, 0, 0, 0, 0, 0, 1, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {-16'sd1, 16'sd0, -16'sd1, 16'sd0}) begin errors++; $display("FAIL scale neg: got %0d %0d %0d %0d exp -1 0 -1 0", o0r, o0i, o1r, o1i); end
    step();
  endtask
  task automatic test_sat();
    int lat;
    send(32767, 0, 256, 0, 256, 0, 0, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {16'sd32767, 16'sd0, 16'sd32511, 16'sd0}) begin errors++; $display("FAIL sat data: got %0d %0d %0d %0d exp 32767 0 32511 0", o0r, o0i, o1r, o1i); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat early ovf: got %b exp 0", ovf); end
    step();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat ovf set: got %b exp 1", ovf); end
    repeat (3) step();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat ovf held: got %b exp 1", ovf); end
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat ovf clr: got %b exp 0", ovf); end
    ovf_clr = 1;
    send(-32768, 0, 256, 0, 256, 0, 0, 0, lat);
    checks++; if ({o0r, o0i, o1r, o1i} !== {-16'sd32512, 16'sd0, -16'sd32768, 16'sd0}) begin errors++; $display("FAIL sat neg data: got %0d %0d %0d %0d exp -32512 0 -32768 0", o0r, o0i, o1r, o1i); end
    step();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat set wins: got %b exp 1", ovf); end
    step();
    ovf_clr = 0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat ovf clr2: got %b exp 0", ovf); end
  endtask
  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 0;
    logic [63:0] hold = '0;
    beat_t e;
    q.delete();
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      valid = sent < 8;
      rand_in();
      #1;
      if (stalled) begin
        checks++; if ({o0r, o0i, o1r, o1i} !== hold) begin errors++; $display("FAIL b2b hold: got %h exp %h", {o0r, o0i, o1r, o1i}, hold); end
      end
      if (o_valid && !out_ready) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b ready: got %b exp 0", ready); end
      end
      if (o_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b extra beat: got %0d exp none", o0r); end
        else begin
          e = q.pop_front();
          got++;
          if (longint'(o0r) != e.o0r || longint'(o0i) != e.o0i || longint'(o1r) != e.o1r || longint'(o1i) != e.o1i) begin
            errors++; $display("FAIL b2b data: got %0d %0d %0d %0d exp %0d %0d %0d %0d", o0r, o0i, o1r, o1i, e.o0r, e.o0i, e.o1r, e.o1i);
          end
        end
      end
      if (valid && ready) begin
        q.push_back(model());
        sent++;
      end
      stalled = o_valid && !out_ready;
      hold = {o0r, o0i, o1r, o1i};
      step();
      cyc++;
    end
    valid = 0; out_ready = 1;
    checks++; if (got != 8 || q.size() != 0) begin errors++; $display("FAIL b2b count: got %0d exp 8", got); end
    step();
  endtask
  task automatic test_random();
    bit exp_ovf = 0, set;
    int got = 0, sent = 0;
    beat_t e;
    q.delete();
    ovf_clr = 1;
    step();
    for (int c = 0; c < 340; c++) begin
      out_ready = c >= 300 || $urandom_range(3) != 0;
      valid = c < 300 && $urandom_range(9) < 7;
      ovf_clr = $urandom_range(9) == 0;
      rand_in();
      #1;
      set = 0;
      if (o_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand extra beat: got %0d exp none", o0r); end
        else begin
          e = q.pop_front();
          got++;
          set = e.clip;
          if (longint'(o0r) != e.o0r || longint'(o0i) != e.o0i || longint'(o1r) != e.o1r || longint'(o1i) != e.o1i) begin
            errors++; $display("FAIL rand data: got %0d %0d %0d %0d exp %0d %0d %0d %0d", o0r, o0i, o1r, o1i, e.o0r, e.o0i, e.o1r, e.o1i);
          end
        end
      end
      if (valid && ready) begin
        q.push_back(model());
        sent++;
      end
      exp_ovf = set ? 1'b1 : ovf_clr ? 1'b0 : exp_ovf;
      step();
      checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rand ovf: got %b exp %b", ovf, exp_ovf); end
    end
    valid = 0; ovf_clr = 1;
    step();
    ovf_clr = 0;
    checks++; if (got != sent || q.size() != 0) begin errors++; $display("FAIL rand count: got %0d exp %0d", got, sent); end
  endtask
  task automatic test_reset_flight();
    out_ready = 1; valid = 1;
    repeat (3) begin
      rand_in();
      step();
    end
    valid = 0; rst = 1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flight valid: got %b exp 0", o_valid); end
    rst = 0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flight ready: got %b exp 1", ready); end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flight stale beat at %0d: got %b exp 0", c, o_valid); end
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    test_reset();
    test_basic();
    test_conj();
    test_round();
    test_sat();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/butterfly2_stream.md
BUTTERFLY2_STREAM -- requirements
Module: butterfly2_stream

Interface
REQ-001 SHALL have parameter N, default 16, sample word width (signed two's complement, per real/imag part).
REQ-002 SHALL have parameter Q, default 8, number of fractional bits in every sample and twiddle word; legal range 1..N-2.
REQ-003 SHALL have i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have i_valid  input  1  input beat valid.
REQ-006 SHALL have o_ready  output  1  block accepts an input beat this cycle.
REQ-007 SHALL have i_in0_re, i_in0_im, i_in1_re, i_in1_im  input  N each  butterfly operands a and b.
REQ-008 SHALL have i_twiddle_re, i_twiddle_im  input  N each  twiddle W.
REQ-009 SHALL have i_conj  input  1  per-beat flag: use conj(W) (inverse transform).
REQ-010 SHALL have i_scale  input  1  per-beat flag: divide both outputs by 2 with rounding.
REQ-011 SHALL have o_valid  output  1  output beat valid.
REQ-012 SHALL have i_out_ready  input  1  downstream accepts the output beat.
REQ-013 SHALL have o_out0_re, o_out0_im, o_out1_re, o_out1_im  output  N each  results.
REQ-014 SHALL have o_ovf  output  1  sticky saturation flag.
REQ-015 SHALL have i_ovf_clr  input  1  clears o_ovf.

Function
REQ-016 SHALL compute per beat t = b*W' (W' = conj(W) when i_conj=1), o_out0 = a + t, o_out1 = a - t.
REQ-017 SHALL form the four partial products at full 2N-bit precision; t_re = re*re - im*im, t_im = re*im + im*re at 2N+1 bits.
REQ-018 SHALL round t to Q fractional bits by adding 2^(Q-1), then arithmetic shift right by Q (round half up), keeping N+2 bits.
REQ-019 SHALL form the sums/differences at N+2 bits; when i_scale=1, SHALL add 1 and arithmetically shift right by 1.
REQ-020 SHALL saturate each of the four results to [-2^(N-1), 2^(N-1)-1]; any clipped result in an accepted output beat SHALL set o_ovf the cycle after the beat transfers.
REQ-021 SHALL be a 3-stage pipeline: S1 register operands/products, S2 rounded t plus delayed a, S3 sums, scale, saturate into output registers; latency 3 cycles from input transfer to o_valid with no stall.
REQ-022 SHALL advance all stages together on enable en = !o_valid || i_out_ready; o_ready = en.
REQ-023 Input transfer SHALL occur when i_valid && o_ready; output transfer when o_valid && i_out_ready.
REQ-024 Throughput SHALL be one beat per cycle while i_out_ready=1.
REQ-025 While en=0 all pipeline registers, valids and outputs SHALL hold; bubbles SHALL propagate as valid=0 stages.
REQ-026 i_conj and i_scale SHALL travel with their beat; changing them mid-stream SHALL affect only later beats.
REQ-027 i_ovf_clr and a same-cycle new saturation event: set SHALL win.
REQ-028 Output data values while o_valid=0 are don't-care; o_valid SHALL never assert without a corresponding input transfer.

Reset
REQ-029 On i_rst=1, all stage valids, o_valid and o_ovf SHALL be 0 on the following edge; data registers need not reset.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; o_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Shared package SHALL hold the latency constant (3), the saturate and round helper functions, and the N+2 intermediate width expression.
REQ-032 A single sub-module cmul_round (complex multiply + REQ-018 rounding, 2-stage, with enable) SHALL be instantiated once; the rest resides in butterfly2_stream.

Verification (N=16, Q=8, 1.0 = 256)
REQ-033 a=(256,0), b=(256,0), W=(256,0), scale=0 -> out0=(512,0), out1=(0,0), o_valid exactly 3 cycles after input transfer.
REQ-034 a=(0,0), b=(256,0), W=(0,256), conj=1 -> out0=(0,-256), out1=(0,256); same beat with conj=0 -> out0=(0,256), out1=(0,-256).
REQ-035 Rounding: a=(0,0), b=(1,0), W=(128,0) -> out0=(1,0), out1=(-1,0); with scale=1, a=(3,0), b=(0,0) -> out0=(2,0).
REQ-036 Saturation: a=(32767,0), b=(256,0), W=(256,0) -> out0=(32767,0), out1=(32511,0), o_ovf=1 and held; i_ovf_clr pulse -> o_ovf=0.
REQ-037 Back-to-back 8 beats with i_out_ready=0 for cycles 4-7 -> no beat lost or duplicated, outputs stable while stalled, o_ready=0 during stall, order preserved.
REQ-038 Assert i_rst with 3 beats in flight -> o_valid=0 next cycle, no stale beat emerges after release.
